// File: rtl/dig_spi_seq_pkg.sv
// dig_spi_seq_pkg: states, table entry layout and default ADC init table for dig_spi_sequencer.
// The VER_XFER state is only entered when DIG_SPI_SEQ_VERIFY_EN is defined.
package dig_spi_seq_pkg;
    typedef enum logic [2:0] {
        IDLE, SETTLE, ARB, SEQ_XFER, VER_XFER, HOST_XFER, GAP, DONE
    } seq_state_t;
    localparam int ADDR_MSB  = 15;
    localparam int ADDR_LSB  = 8;
    localparam int DATA_MSB  = 7;
    localparam int DATA_LSB  = 0;
    localparam int READ_FLAG = 15;
    // entry 0 sits in the low 16 bits: soft reset first, then format and test-pattern setup
    localparam logic [16*8-1:0] DIG_SEQ_DEFAULT_TABLE = {
        16'h1500, 16'h1400, 16'h0f00, 16'h0e00, 16'h0d00, 16'h0c04, 16'h0103, 16'h0080
    };
    function automatic logic [15:0] ver_word(logic [15:0] w);
        logic [15:0] r;
        r = '0;
        r[READ_FLAG] = 1'b1;
        r[ADDR_MSB-1:ADDR_LSB] = w[ADDR_MSB-1:ADDR_LSB];
        return r;
    endfunction
endpackage

// File: rtl/dig_spi_sequencer_if.sv
// dig_spi_sequencer_if: one SPI transaction channel (request level, select, word out, ack pulse, byte back).
// Used both for the host-to-sequencer link and for the sequencer-to-spi_master link.
interface dig_spi_sequencer_if;
    logic        req;
    logic        sel;
    logic [15:0] wr_data;
    logic        ack;
    logic [7:0]  rd_data;
    modport master (output req, sel, wr_data, input ack, rd_data);
    modport slave (input req, sel, wr_data, output ack, rd_data);
endinterface

// File: rtl/dig_spi_rr_arb.sv
// dig_spi_rr_arb: two-requester round-robin arbiter; req[0] = sequencer, req[1] = host.
module dig_spi_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic last;
    always_comb gnt = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 1'b0;
        else if (en && |gnt) last <= gnt[1];
    end
endmodule

// File: rtl/dig_spi_sequencer.sv
// dig_spi_sequencer: plays an ADC init table over the shared digitizer SPI master, arbitrated with host accesses.
// Define DIG_SPI_SEQ_VERIFY_EN to read back and compare every written word.
module dig_spi_sequencer
    import dig_spi_seq_pkg::*;
#(
    parameter int P_N_WORDS       = 8,
    parameter int P_N_CHANNELS    = 2,
    parameter int P_SETTLE_CYCLES = 1024,
    parameter int P_GAP_CYCLES    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [16*P_N_WORDS-1:0]  seq_table,
    dig_spi_sequencer_if.slave       host,
    dig_spi_sequencer_if.master      spi,
    output logic                     seq_busy,
    output logic                     seq_done,
    output logic                     seq_err,
    output logic [7:0]               seq_err_idx
);
    localparam int EW = P_N_WORDS > 1 ? $clog2(P_N_WORDS) : 1;
    localparam int CW = P_N_CHANNELS > 1 ? $clog2(P_N_CHANNELS) : 1;
    localparam int SW = $clog2(P_SETTLE_CYCLES + 1);
    localparam int GW = $clog2(P_GAP_CYCLES + 1);
    localparam logic [EW-1:0] E_LAST = EW'(P_N_WORDS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(P_N_CHANNELS - 1);
    seq_state_t state, nxt;
    logic [EW-1:0] entry;
    logic [CW-1:0] ch;
    logic [SW-1:0] settle_cnt;
    logic [GW-1:0] gap_cnt;
    logic busy, done, fin, adv, settle_end, unit_last, arb_en;
    logic [1:0] arb_req, gnt;
    logic [15:0] word;
`ifdef DIG_SPI_SEQ_VERIFY_EN
    logic ver_pend, err;
    logic [7:0] err_idx;
`endif
    assign word = seq_table[16*int'(entry) +: 16];
    assign settle_end = int'(settle_cnt) <= 1;
    assign unit_last = entry == E_LAST && ch == C_LAST;
    assign seq_busy = busy;
    assign seq_done = done;
`ifdef DIG_SPI_SEQ_VERIFY_EN
    assign adv = state == VER_XFER && spi.ack;
`else
    assign adv = state == SEQ_XFER && spi.ack;
`endif
    dig_spi_rr_arb u_arb (.clk(clk), .rst(rst), .req(arb_req), .en(arb_en), .gnt(gnt));
    always_comb begin
        nxt = state;
        arb_req = '0;
        arb_en = 1'b0;
        case (state)
            IDLE: begin
                arb_req = {host.req, 1'b0};
                arb_en = 1'b1;
                nxt = host.req ? HOST_XFER : (start ? SETTLE : IDLE);
            end
            SETTLE: begin
                arb_req = {host.req && !settle_end, 1'b0};
                arb_en = 1'b1;
                nxt = settle_end ? ARB : (host.req ? HOST_XFER : SETTLE);
            end
            ARB: begin
                arb_req = {host.req, 1'b1};
                arb_en = 1'b1;
                nxt = gnt[1] ? HOST_XFER : (gnt[0] ? SEQ_XFER : ARB);
            end
            SEQ_XFER:  nxt = spi.ack ? GAP : SEQ_XFER;
            HOST_XFER: nxt = spi.ack ? GAP : HOST_XFER;
`ifdef DIG_SPI_SEQ_VERIFY_EN
            VER_XFER:  nxt = spi.ack ? GAP : VER_XFER;
            // the read-back follows its write without re-arbitration
            GAP: nxt = gap_cnt != '0 ? GAP : !busy ? IDLE : ver_pend ? VER_XFER : fin ? DONE : settle_end ? ARB : SETTLE;
`else
            GAP: nxt = gap_cnt != '0 ? GAP : !busy ? IDLE : fin ? DONE : settle_end ? ARB : SETTLE;
`endif
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE; busy <= 1'b0; done <= 1'b0; fin <= 1'b0;
            entry <= '0; ch <= '0; settle_cnt <= '0; gap_cnt <= '0;
            spi.req <= 1'b0; spi.sel <= 1'b0; spi.wr_data <= '0;
            host.ack <= 1'b0; host.rd_data <= '0;
        end else begin
            state <= nxt;
            spi.req <= nxt == SEQ_XFER || nxt == VER_XFER || nxt == HOST_XFER;
            if (nxt != state && (nxt == SEQ_XFER || nxt == VER_XFER || nxt == HOST_XFER)) begin
                spi.sel <= nxt == HOST_XFER ? host.sel : ch[0];
                spi.wr_data <= nxt == HOST_XFER ? host.wr_data : (nxt == VER_XFER ? ver_word(word) : word);
            end
            host.ack <= state == HOST_XFER && spi.ack;
            if (state == HOST_XFER && spi.ack) host.rd_data <= spi.rd_data;
            gap_cnt <= nxt == GAP && state != GAP ? GW'(P_GAP_CYCLES - 1) : (gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt);
            // settle keeps counting while host transfers are served
            if (start && !busy) begin
                busy <= 1'b1; done <= 1'b0; fin <= 1'b0; entry <= '0; ch <= '0;
                settle_cnt <= SW'(P_SETTLE_CYCLES - 1);
            end else begin
                if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                if (state == DONE) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                if (adv) begin
                    fin <= unit_last;
                    ch <= ch == C_LAST ? '0 : ch + 1'b1;
                    if (ch == C_LAST) entry <= entry == E_LAST ? '0 : entry + 1'b1;
                end
            end
        end
    end
`ifdef DIG_SPI_SEQ_VERIFY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ver_pend <= 1'b0; err <= 1'b0; err_idx <= '0;
        end else begin
            ver_pend <= state == SEQ_XFER && spi.ack ? 1'b1 : (state == VER_XFER ? 1'b0 : ver_pend);
            if (start && !busy) begin
                err <= 1'b0;
                err_idx <= '0;
            end else if (adv && !err && spi.rd_data != word[DATA_MSB:DATA_LSB]) begin
                err <= 1'b1;
                err_idx <= {7'(entry), ch[0]};
            end
        end
    end
    assign seq_err = err;
    assign seq_err_idx = err_idx;
`else
    assign seq_err = 1'b0;
    assign seq_err_idx = '0;
`endif
endmodule

// File: tb/tb_dig_spi_sequencer.sv
// tb_dig_spi_sequencer: directed bench with a 20-cycle-ack spi_master model and a transaction log.
module tb_dig_spi_sequencer;
`ifdef DIG_SPI_SEQ_VERIFY_EN
    localparam int UNIT = 2;
`else
    localparam int UNIT = 1;
`endif
    localparam int GAP = 4;
    logic clk, rst, start, bad_en;
    logic seq_busy, seq_done, seq_err;
    logic [7:0] seq_err_idx;
    logic [31:0] table_w;
    logic [16:0] log_q[$];
    logic [16:0] exp_q[$];
    int n_chk, n_err, gap_viol, lat;
    dig_spi_sequencer_if host_if ();
    dig_spi_sequencer_if spi_if ();
    dig_spi_sequencer #(
        .P_N_WORDS(2), .P_N_CHANNELS(2), .P_SETTLE_CYCLES(16), .P_GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seq_table(table_w),
        .host(host_if), .spi(spi_if),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err), .seq_err_idx(seq_err_idx)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    function automatic logic [7:0] resp(logic sel, logic [15:0] w);
        if (w == 16'h8A00) return 8'h5C;
        if (w == 16'h8B00) return 8'hA7;
        if (bad_en && !sel && w[14:8] == 7'h03) return 8'hFF;
        return w[14:8] == 7'h01 ? 8'h02 : (w[14:8] == 7'h03 ? 8'h04 : 8'h00);
    endfunction
    // spi_master model: ack in the 20th request cycle, logs each transaction and short gaps
    initial begin
        int xcnt, low_cnt;
        logic req_q, seen;
        xcnt = 0; low_cnt = 0; req_q = 0; seen = 0;
        spi_if.ack = 0; spi_if.rd_data = 0;
        forever begin
            @(posedge clk); #1;
            spi_if.ack = 0;
            if (rst) xcnt = 0;
            if (spi_if.req && !rst) begin
                if (!req_q) begin
                    log_q.push_back({spi_if.sel, spi_if.wr_data});
                    if (seen && low_cnt < GAP) gap_viol++;
                    seen = 1;
                end
                xcnt++;
                if (xcnt == 20) begin
                    spi_if.ack = 1;
                    spi_if.rd_data = resp(spi_if.sel, spi_if.wr_data);
                    xcnt = 0;
                end
                low_cnt = 0;
            end else low_cnt++;
            req_q = spi_if.req;
        end
    end
    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask
    task automatic build_exp();
        logic [15:0] w;
        exp_q.delete();
        for (int e = 0; e < 2; e++)
            for (int c = 0; c < 2; c++) begin
                w = e != 0 ? 16'h0304 : 16'h0102;
                exp_q.push_back({c[0], w});
`ifdef DIG_SPI_SEQ_VERIFY_EN
                exp_q.push_back({c[0], 1'b1, w[14:8], 8'h00});
`endif
            end
    endtask
    task automatic check_log(string tag);
        repeat (30) @(posedge clk);
        #1;
        chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_xfer%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask
    task automatic start_seq(output int n);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        n = 1;
        while (!spi_if.req && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic wait_done(string tag);
        int n = 0;
        while (!seq_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, 32'(seq_done), 1);
        chk({tag, "_busy"}, 32'(seq_busy), 0);
    endtask
    task automatic wait_ack(string tag, logic [7:0] want);
        int n = 0;
        while (!host_if.ack && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ack"}, 32'(host_if.ack), 1);
        chk({tag, "_rd"}, 32'(host_if.rd_data), 32'(want));
        host_if.req = 0;
    endtask
    initial begin
        n_chk = 0; n_err = 0; gap_viol = 0;
        rst = 1; start = 0; bad_en = 0; table_w = {16'h0304, 16'h0102};
        host_if.req = 0; host_if.sel = 0; host_if.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(spi_if.req), 0);
        chk("rst_busy", 32'(seq_busy), 0);
        chk("rst_done", 32'(seq_done), 0);
        chk("rst_ack", 32'(host_if.ack), 0);
        chk("rst_err", 32'({seq_err, seq_err_idx}), 0);
        rst = 0;
        log_q.delete();
        start_seq(lat);
        chk("a_first_req_lat", 32'(lat), 17);
        wait_done("a");
        chk("a_err", 32'({seq_err, seq_err_idx}), 0);
        build_exp();
        check_log("a");
        log_q.delete();
        start_seq(lat);
        host_if.req = 1; host_if.sel = 1; host_if.wr_data = 16'h8A00;
        wait_ack("b", 8'h5C);
        wait_done("b");
        build_exp();
        exp_q.insert(UNIT, 17'h18A00);
        check_log("b");
        chk("b_rd_hold", 32'(host_if.rd_data), 32'h5C);
        log_q.delete();
        @(posedge clk); #1;
        start = 1; host_if.req = 1; host_if.sel = 0; host_if.wr_data = 16'h8B00;
        @(posedge clk); #1 start = 0;
        wait_ack("d", 8'hA7);
        wait_done("d");
        build_exp();
        exp_q.push_front(17'h08B00);
        check_log("d");
        start_seq(lat);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("e_rst_req", 32'(spi_if.req), 0);
        chk("e_rst_busy", 32'(seq_busy), 0);
        chk("e_rst_wr", 32'(spi_if.wr_data), 0);
        chk("e_rst_rd", 32'(host_if.rd_data), 0);
        @(posedge clk); #1 rst = 0;
        log_q.delete();
        start_seq(lat);
        chk("e_first_req_lat", 32'(lat), 17);
        wait_done("e");
        build_exp();
        check_log("e");
`ifdef DIG_SPI_SEQ_VERIFY_EN
        bad_en = 1;
        log_q.delete();
        start_seq(lat);
        wait_done("f");
        chk("f_err", 32'(seq_err), 1);
        chk("f_err_idx", 32'(seq_err_idx), 32'h02);
        build_exp();
        check_log("f");
        bad_en = 0;
`endif
        chk("gap_violations", 32'(gap_viol), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
